// File: rtl/network_mod_rx_chan_arbiter_pkg.sv
// rtl/network_mod_rx_chan_arbiter_pkg.sv - shared types and helpers for the RX channel arbiter
//
// Package network_mod_rx_arb_pkg
//   fsm_state_t    : arbiter state (IDLE = free to pick, LOCKED = packet in flight)
//   chan_w()       : channel index width, at least 1 bit
//   pos_w()        : position field width, at least 1 bit
//   word_opens()   : word starts a packet that continues into the next word
//   word_closes()  : word ends the packet that is currently open
package network_mod_rx_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fsm_state_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pos_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // An SOF block positioned after the EOF item belongs to a new packet
    // that carries on into the next word.
    function automatic logic word_opens(input logic sof, input logic eof,
                                        input int sof_pos, input int eof_pos,
                                        input int block_size);
        return sof && (!eof || (sof_pos * block_size > eof_pos));
    endfunction

    function automatic logic word_closes(input logic sof, input logic eof,
                                         input int sof_pos, input int eof_pos,
                                         input int block_size);
        return eof && !word_opens(sof, eof, sof_pos, eof_pos, block_size);
    endfunction

endpackage

// File: rtl/network_mod_rx_chan_arbiter_if.sv
// rtl/network_mod_rx_chan_arbiter_if.sv - MFB stream bundle carrying one or more channels
//
// Parameters: CHANNELS lanes, each with a DATA_W data word and single-region SOF/EOF.
// Signals   : data, sof, eof, sof_pos, eof_pos, chan (source channel tag),
//             src_rdy (valid per lane), dst_rdy (accept per lane).
// Modports  : master drives the stream, slave accepts it.
interface network_mod_rx_chan_arbiter_if
    import network_mod_rx_arb_pkg::*;
#(
    parameter int CHANNELS    = 1,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int CHAN_W      = 1
);
    localparam int DATA_W    = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int SOF_POS_W = pos_w(REGION_SIZE);
    localparam int EOF_POS_W = pos_w(REGION_SIZE * BLOCK_SIZE);

    logic [CHANNELS*DATA_W-1:0]    data;
    logic [CHANNELS-1:0]           sof;
    logic [CHANNELS-1:0]           eof;
    logic [CHANNELS*SOF_POS_W-1:0] sof_pos;
    logic [CHANNELS*EOF_POS_W-1:0] eof_pos;
    logic [CHAN_W-1:0]             chan;
    logic [CHANNELS-1:0]           src_rdy;
    logic [CHANNELS-1:0]           dst_rdy;

    modport master (
        output data, sof, eof, sof_pos, eof_pos, chan, src_rdy,
        input  dst_rdy
    );

    modport slave (
        input  data, sof, eof, sof_pos, eof_pos, chan, src_rdy,
        output dst_rdy
    );

endinterface

// File: rtl/network_mod_rx_chan_arbiter_rr_select.sv
// rtl/network_mod_rx_chan_arbiter_rr_select.sv - combinational round-robin requester picker
//
// Ports: req (request per channel), ptr (highest-priority channel),
//        idx (chosen channel, equals ptr when nobody requests), vld (some request present).
module network_mod_rx_chan_arbiter_rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Scan from farthest to nearest so the channel closest to ptr wins.
    always_comb begin
        idx = ptr;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[W'((int'(ptr) + i) % N)]) begin
                idx = W'((int'(ptr) + i) % N);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/network_mod_rx_chan_arbiter.sv
// rtl/network_mod_rx_chan_arbiter.sv - packet-granular round-robin merge of per-channel RX MFB streams
//
// Ports: CLK, RESET (async, active-low),
//        rx : per-channel MFB input (slave), ETH_CHANNELS lanes,
//        tx : merged MFB output (master), one lane, chan = source channel of the word.
// One register stage on the output; a channel keeps the grant from the word that
// opens a packet until the word that closes it.
module network_mod_rx_chan_arbiter
    import network_mod_rx_arb_pkg::*;
#(
    parameter int ETH_CHANNELS = 4,
    parameter int REGION_SIZE  = 8,
    parameter int BLOCK_SIZE   = 8,
    parameter int ITEM_WIDTH   = 8
) (
    input  logic CLK,
    input  logic RESET,
    network_mod_rx_chan_arbiter_if.slave  rx,
    network_mod_rx_chan_arbiter_if.master tx
);

    localparam int DATA_W    = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int SOF_POS_W = pos_w(REGION_SIZE);
    localparam int EOF_POS_W = pos_w(REGION_SIZE * BLOCK_SIZE);
    localparam int CHAN_W    = chan_w(ETH_CHANNELS);

    fsm_state_t           state_q, state_d;
    logic [CHAN_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CHAN_W-1:0]    lock_ch_q, lock_ch_d;
    logic                 tx_vld_q, tx_vld_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 tx_sof_q, tx_sof_d;
    logic                 tx_eof_q, tx_eof_d;
    logic [SOF_POS_W-1:0] tx_sof_pos_q, tx_sof_pos_d;
    logic [EOF_POS_W-1:0] tx_eof_pos_q, tx_eof_pos_d;
    logic [CHAN_W-1:0]    tx_chan_q, tx_chan_d;

    logic [CHAN_W-1:0]    pick_idx;
    logic                 pick_vld;
    logic [CHAN_W-1:0]    sel;
    logic                 out_free;
    logic                 accept;
    logic [DATA_W-1:0]    w_data;
    logic                 w_sof, w_eof, w_src_rdy;
    logic [SOF_POS_W-1:0] w_sof_pos;
    logic [EOF_POS_W-1:0] w_eof_pos;
    logic                 w_opens, w_closes;

    network_mod_rx_chan_arbiter_rr_select #(
        .N (ETH_CHANNELS),
        .W (CHAN_W)
    ) u_rr_select (
        .req (rx.src_rdy),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    function automatic logic [CHAN_W-1:0] next_ch(input logic [CHAN_W-1:0] ch);
        return (int'(ch) == ETH_CHANNELS - 1) ? '0 : ch + CHAN_W'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_ch_d    = lock_ch_q;
        tx_vld_d     = tx_vld_q;
        tx_data_d    = tx_data_q;
        tx_sof_d     = tx_sof_q;
        tx_eof_d     = tx_eof_q;
        tx_sof_pos_d = tx_sof_pos_q;
        tx_eof_pos_d = tx_eof_pos_q;
        tx_chan_d    = tx_chan_q;

        // While locked the owner keeps the grant even when it has nothing to send.
        if (state_q == LOCKED) begin
            sel = lock_ch_q;
        end else begin
            sel = pick_vld ? pick_idx : rr_ptr_q;
        end

        w_data    = '0;
        w_sof     = 1'b0;
        w_eof     = 1'b0;
        w_sof_pos = '0;
        w_eof_pos = '0;
        w_src_rdy = 1'b0;
        for (int c = 0; c < ETH_CHANNELS; c++) begin
            if (CHAN_W'(c) == sel) begin
                w_data    = rx.data[c*DATA_W +: DATA_W];
                w_sof     = rx.sof[c];
                w_eof     = rx.eof[c];
                w_sof_pos = rx.sof_pos[c*SOF_POS_W +: SOF_POS_W];
                w_eof_pos = rx.eof_pos[c*EOF_POS_W +: EOF_POS_W];
                w_src_rdy = rx.src_rdy[c];
            end
        end

        w_opens  = word_opens(w_sof, w_eof, int'(w_sof_pos), int'(w_eof_pos), BLOCK_SIZE);
        w_closes = word_closes(w_sof, w_eof, int'(w_sof_pos), int'(w_eof_pos), BLOCK_SIZE);

        out_free = !tx_vld_q || tx.dst_rdy[0];
        accept   = RESET && out_free && w_src_rdy;

        rx.dst_rdy = '0;
        for (int c = 0; c < ETH_CHANNELS; c++) begin
            rx.dst_rdy[c] = RESET && out_free && (CHAN_W'(c) == sel);
        end

        if (accept) begin
            tx_vld_d     = 1'b1;
            tx_data_d    = w_data;
            tx_sof_d     = w_sof;
            tx_eof_d     = w_eof;
            tx_sof_pos_d = w_sof_pos;
            tx_eof_pos_d = w_eof_pos;
            tx_chan_d    = sel;
            case (state_q)
                IDLE: begin
                    if (w_opens) begin
                        state_d   = LOCKED;
                        lock_ch_d = sel;
                    end else begin
                        rr_ptr_d = next_ch(sel);
                    end
                end
                LOCKED: begin
                    if (w_closes) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ch(lock_ch_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (out_free) begin
            tx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_ch_q    <= '0;
            tx_vld_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_sof_q     <= 1'b0;
            tx_eof_q     <= 1'b0;
            tx_sof_pos_q <= '0;
            tx_eof_pos_q <= '0;
            tx_chan_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_ch_q    <= lock_ch_d;
            tx_vld_q     <= tx_vld_d;
            tx_data_q    <= tx_data_d;
            tx_sof_q     <= tx_sof_d;
            tx_eof_q     <= tx_eof_d;
            tx_sof_pos_q <= tx_sof_pos_d;
            tx_eof_pos_q <= tx_eof_pos_d;
            tx_chan_q    <= tx_chan_d;
        end
    end

    assign tx.data     = tx_data_q;
    assign tx.sof      = tx_sof_q;
    assign tx.eof      = tx_eof_q;
    assign tx.sof_pos  = tx_sof_pos_q;
    assign tx.eof_pos  = tx_eof_pos_q;
    assign tx.chan     = tx_chan_q;
    assign tx.src_rdy  = tx_vld_q;

    // Malformed framing is forwarded untouched; these only flag it in simulation.
    a_sof_while_locked: assert property (@(posedge CLK) disable iff (!RESET)
        (accept && state_q == LOCKED && w_sof) |-> (w_eof && w_opens))
        else $error("rx arbiter: SOF on channel %0d before its EOF", sel);

    a_eof_while_idle: assert property (@(posedge CLK) disable iff (!RESET)
        (accept && state_q == IDLE && w_eof) |-> (w_sof && !w_opens))
        else $error("rx arbiter: EOF on channel %0d without SOF", sel);

endmodule

// File: tb/tb_network_mod_rx_chan_arbiter.sv
// tb/tb_network_mod_rx_chan_arbiter.sv - randomized bench with packet-level reference model
module tb_network_mod_rx_chan_arbiter;
    import network_mod_rx_arb_pkg::*;

    localparam int NCH   = 4;
    localparam int RS    = 8;
    localparam int BS    = 8;
    localparam int IW    = 8;
    localparam int DW    = RS * BS * IW;
    localparam int CW    = chan_w(NCH);
    localparam int NCYC  = 4000;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
        logic [2:0]    sp;
        logic [5:0]    ep;
        bit            cont;   // packet still open after this word
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    network_mod_rx_chan_arbiter_if #(.CHANNELS(NCH), .REGION_SIZE(RS), .BLOCK_SIZE(BS),
                                     .ITEM_WIDTH(IW), .CHAN_W(CW)) rx_if ();
    network_mod_rx_chan_arbiter_if #(.CHANNELS(1), .REGION_SIZE(RS), .BLOCK_SIZE(BS),
                                     .ITEM_WIDTH(IW), .CHAN_W(CW)) tx_if ();

    network_mod_rx_chan_arbiter #(.ETH_CHANNELS(NCH), .REGION_SIZE(RS),
                                  .BLOCK_SIZE(BS), .ITEM_WIDTH(IW)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .rx    (rx_if),
        .tx    (tx_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [599:0] got, input logic [599:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    word_t    cur [NCH];
    bit       in_pkt [NCH];
    logic [NCH-1:0] src;
    logic     tx_rdy;

    // Reference state: which channel owns the output (-1 = none), next priority channel,
    // and the word expected on the output register.
    int       owner;
    int       ptr;
    bit       exp_vld;
    word_t    exp_w;
    int       exp_ch;
    int       words_seen;

    function automatic word_t gen_word(input bit inp);
        word_t w;
        for (int i = 0; i < DW / 32; i++) w.data[i*32 +: 32] = $urandom;
        w.sp = 3'($urandom_range(0, 7));
        w.ep = 6'($urandom_range(0, 63));
        if (!inp) begin
            w.sof = 1'b1;
            if ($urandom_range(0, 9) < 4) begin
                w.eof  = 1'b1;
                w.ep   = 6'(int'(w.sp) * 8 + $urandom_range(0, 63 - int'(w.sp) * 8));
                w.cont = 1'b0;
            end else begin
                w.eof  = 1'b0;
                w.cont = 1'b1;
            end
        end else begin
            w.sof  = 1'b0;
            w.eof  = ($urandom_range(0, 2) == 0);
            w.cont = !w.eof;
            if (w.eof && w.ep < 56 && $urandom_range(0, 2) == 0) begin
                int lo;
                lo     = int'(w.ep) / 8 + 1;
                w.sp   = 3'($urandom_range(lo, 7));
                w.sof  = 1'b1;
                w.cont = 1'b1;
            end
        end
        return w;
    endfunction

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            rx_if.data[c*DW +: DW] = cur[c].data;
            rx_if.sof[c]           = cur[c].sof;
            rx_if.eof[c]           = cur[c].eof;
            rx_if.sof_pos[c*3 +: 3] = cur[c].sp;
            rx_if.eof_pos[c*6 +: 6] = cur[c].ep;
        end
        rx_if.src_rdy = src;
        rx_if.chan    = '0;
        tx_if.dst_rdy = tx_rdy;
    endtask

    task automatic fresh_streams();
        for (int c = 0; c < NCH; c++) begin
            in_pkt[c] = 1'b0;
            cur[c]    = gen_word(1'b0);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        ptr     = 0;
        exp_vld = 1'b0;
    endtask

    function automatic logic [599:0] tx_packed();
        return 600'({tx_if.data, tx_if.sof, tx_if.eof, tx_if.sof_pos, tx_if.eof_pos, tx_if.chan});
    endfunction

    function automatic logic [599:0] exp_packed();
        return 600'({exp_w.data, exp_w.sof, exp_w.eof, exp_w.sp, exp_w.ep, CW'(exp_ch)});
    endfunction

    initial begin
        int  acc_ch;
        bit  regen;
        int  sel;
        bit  free;
        logic [NCH-1:0] exp_dst;

        words_seen = 0;
        fresh_streams();
        src    = '0;
        tx_rdy = 1'b0;
        drive();
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_eq("reset_tx_src_rdy", 600'(tx_if.src_rdy), 600'(0));
        check_eq("reset_rx_dst_rdy", 600'(rx_if.dst_rdy), 600'(0));
        check_eq("reset_tx_fields", tx_packed(), 600'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            acc_ch = -1;
            regen  = 1'b0;
            if (!rst_n) begin
                check_eq("rst_tx_src_rdy", 600'(tx_if.src_rdy), 600'(0));
                check_eq("rst_rx_dst_rdy", 600'(rx_if.dst_rdy), 600'(0));
                check_eq("rst_tx_fields", tx_packed(), 600'(0));
                model_reset();
                regen = 1'b1;
            end else begin
                check_eq("tx_src_rdy", 600'(tx_if.src_rdy), 600'(exp_vld));
                if (exp_vld && tx_if.src_rdy[0]) begin
                    check_eq("tx_word", tx_packed(), exp_packed());
                    if (tx_rdy) words_seen++;
                end
                free = !exp_vld || tx_rdy;
                if (owner >= 0) begin
                    sel = owner;
                end else begin
                    sel = ptr;
                    for (int k = NCH - 1; k >= 0; k--)
                        if (src[(ptr + k) % NCH]) sel = (ptr + k) % NCH;
                end
                exp_dst = free ? NCH'(1 << sel) : '0;
                check_eq("rx_dst_rdy", 600'(rx_if.dst_rdy), 600'(exp_dst));
                if (free && src[sel]) begin
                    acc_ch  = sel;
                    exp_vld = 1'b1;
                    exp_w   = cur[sel];
                    exp_ch  = sel;
                    if (owner >= 0) begin
                        if (!cur[sel].cont) begin
                            owner = -1;
                            ptr   = (sel + 1) % NCH;
                        end
                    end else if (cur[sel].cont) begin
                        owner = sel;
                    end else begin
                        ptr = (sel + 1) % NCH;
                    end
                end else if (free) begin
                    exp_vld = 1'b0;
                end
            end

            @(posedge clk); #1;
            if (regen) begin
                fresh_streams();
            end else if (acc_ch >= 0) begin
                in_pkt[acc_ch] = cur[acc_ch].cont;
                cur[acc_ch]    = gen_word(in_pkt[acc_ch]);
            end
            for (int c = 0; c < NCH; c++) src[c] = ($urandom_range(0, 9) < 6);
            // Occasionally all channels request at once to exercise the round-robin order.
            if ($urandom_range(0, 7) == 0) src = '1;
            tx_rdy = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            drive();
        end

        check_eq("words_delivered", 600'(words_seen > 100), 600'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
